// File: rtl/mem_wb_stage_pkg.sv
// Shared types and helpers for the MEM/WB writeback stage.
// The state encoding is fixed: WB_IDLE=0, WB_WAIT_LOAD=1.
package mem_wb_stage_pkg;

    localparam int RD_W   = 5;
    localparam int DATA_W = 32;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

    // x0 is hardwired to zero, so a write to it is dropped
    function automatic logic rd_writes(input logic reg_write, input logic [RD_W-1:0] rd);
        return reg_write & (rd != '0);
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback controller with a stalling,
// timeout-guarded wait for multi-cycle loads and a retired-instruction counter.
//
// state        | meaning
// WB_IDLE      | accepting one instruction per cycle from the memory stage
// WB_WAIT_LOAD | load outstanding, upstream frozen, wait counter running
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_is_load,
    input  logic              mem_reg_write,
    input  logic [RD_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] calculated_result,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_data_valid,
    input  logic              load_resp_err,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_write_data,
    output logic              bus_err,
    output logic              timeout_err,
    output logic [31:0]       retire_count
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOAD_TIMEOUT);

    wb_state_e         state, state_next;
    logic [CNT_W-1:0]  wait_cnt, cnt_next;
    logic [RD_W-1:0]   cap_rd, cap_rd_next;
    logic              cap_rw, cap_rw_next;
    logic              wb_load;
    logic              wb_rw_d;
    logic [RD_W-1:0]   wb_rd_d;
    logic [DATA_W-1:0] wb_data_d;
    logic              set_bus_err;
    logic              set_timeout;

    always_comb begin
        state_next  = state;
        cnt_next    = wait_cnt;
        cap_rd_next = cap_rd;
        cap_rw_next = cap_rw;
        wb_load     = 1'b0;
        wb_rw_d     = 1'b0;
        wb_rd_d     = wb_rd;
        wb_data_d   = wb_write_data;
        set_bus_err = 1'b0;
        set_timeout = 1'b0;
        mem_stall   = 1'b0;

        case (state)
            WB_IDLE: begin
                if (mem_valid) begin
                    if (!mem_is_load) begin
                        wb_load   = 1'b1;
                        wb_rw_d   = rd_writes(mem_reg_write, mem_rd);
                        wb_rd_d   = mem_rd;
                        wb_data_d = calculated_result;
                    end else if (load_data_valid) begin
                        wb_load     = 1'b1;
                        wb_rw_d     = rd_writes(mem_reg_write, mem_rd);
                        wb_rd_d     = mem_rd;
                        wb_data_d   = load_data;
                        set_bus_err = load_resp_err;
                    end else begin
                        mem_stall   = 1'b1;
                        cap_rd_next = mem_rd;
                        cap_rw_next = mem_reg_write;
                        cnt_next    = CNT_W'(1);
                        state_next  = WB_WAIT_LOAD;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                // data arriving on the timeout cycle still wins
                if (load_data_valid) begin
                    wb_load     = 1'b1;
                    wb_rw_d     = rd_writes(cap_rw, cap_rd);
                    wb_rd_d     = cap_rd;
                    wb_data_d   = load_data;
                    set_bus_err = load_resp_err;
                    state_next  = WB_IDLE;
                end else if (wait_cnt == CNT_LIMIT) begin
                    wb_load     = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = WB_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_next  = wait_cnt + CNT_W'(1);
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WB_IDLE;
            wait_cnt      <= '0;
            cap_rd        <= '0;
            cap_rw        <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_write_data <= '0;
            bus_err       <= 1'b0;
            timeout_err   <= 1'b0;
            retire_count  <= '0;
        end else begin
            state        <= state_next;
            wait_cnt     <= cnt_next;
            cap_rd       <= cap_rd_next;
            cap_rw       <= cap_rw_next;
            wb_valid     <= wb_load;
            wb_reg_write <= wb_rw_d;
            if (wb_load) begin
                wb_rd         <= wb_rd_d;
                wb_write_data <= wb_data_d;
            end
            bus_err     <= bus_err | set_bus_err;
            timeout_err <= timeout_err | set_timeout;
            if (wb_valid) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with LOAD_TIMEOUT=4; inputs change on the
// falling edge and outputs are sampled on the following falling edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_is_load;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] calculated_result;
    logic [31:0] load_data;
    logic        load_data_valid;
    logic        load_resp_err;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_write_data;
    logic        bus_err;
    logic        timeout_err;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;
    int stall_cycles;

    mem_wb_stage #(.LOAD_TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid         (mem_valid),
        .mem_is_load       (mem_is_load),
        .mem_reg_write     (mem_reg_write),
        .mem_rd            (mem_rd),
        .calculated_result (calculated_result),
        .load_data         (load_data),
        .load_data_valid   (load_data_valid),
        .load_resp_err     (load_resp_err),
        .mem_stall         (mem_stall),
        .wb_valid          (wb_valid),
        .wb_reg_write      (wb_reg_write),
        .wb_rd             (wb_rd),
        .wb_write_data     (wb_write_data),
        .bus_err           (bus_err),
        .timeout_err       (timeout_err),
        .retire_count      (retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        mem_valid       = 1'b0;
        mem_is_load     = 1'b0;
        mem_reg_write   = 1'b0;
        mem_rd          = 5'd0;
        load_data_valid = 1'b0;
        load_resp_err   = 1'b0;
    endtask

    task automatic drive_op(input logic is_load, input logic [4:0] rd, input logic [31:0] res);
        mem_valid         = 1'b1;
        mem_is_load       = is_load;
        mem_reg_write     = 1'b1;
        mem_rd            = rd;
        calculated_result = res;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},   32'(mem_stall),    32'd0);
        chk({tag, "_valid"},   32'(wb_valid),     32'd0);
        chk({tag, "_rw"},      32'(wb_reg_write), 32'd0);
        chk({tag, "_rd"},      32'(wb_rd),        32'd0);
        chk({tag, "_data"},    wb_write_data,     32'd0);
        chk({tag, "_buserr"},  32'(bus_err),      32'd0);
        chk({tag, "_timeout"}, 32'(timeout_err),  32'd0);
        chk({tag, "_retire"},  retire_count,      32'd0);
    endtask

    initial begin
        rst               = 1'b1;
        calculated_result = 32'd0;
        load_data         = 32'd0;
        drive_idle();
        @(negedge clk);
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        // ALU op rd=5
        drive_op(1'b0, 5'd5, 32'h0000_1234);
        #1 chk("alu_stall", 32'(mem_stall), 32'd0);
        cyc();
        chk("alu_valid", 32'(wb_valid), 32'd1);
        chk("alu_rw",    32'(wb_reg_write), 32'd1);
        chk("alu_rd",    32'(wb_rd), 32'd5);
        chk("alu_data",  wb_write_data, 32'h0000_1234);
        drive_idle();
        cyc();
        chk("alu_valid_drop", 32'(wb_valid), 32'd0);
        chk("alu_retire", retire_count, 32'd1);

        // load with data in the same cycle
        drive_op(1'b1, 5'd7, 32'h0000_0100);
        load_data       = 32'hFFFF_FF80;
        load_data_valid = 1'b1;
        #1 chk("ld0_stall", 32'(mem_stall), 32'd0);
        cyc();
        chk("ld0_valid", 32'(wb_valid), 32'd1);
        chk("ld0_rd",    32'(wb_rd), 32'd7);
        chk("ld0_data",  wb_write_data, 32'hFFFF_FF80);
        chk("ld0_stall_after", 32'(mem_stall), 32'd0);
        drive_idle();
        cyc();
        chk("ld0_retire", retire_count, 32'd2);

        // load with data 3 cycles late; mem_* junk during the wait must be ignored
        drive_op(1'b1, 5'd9, 32'h0000_0200);
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            #1 if (mem_stall) stall_cycles++;
            cyc();
            mem_rd      = 5'd3;
            mem_is_load = 1'b0;
            chk("ld3_no_wb", 32'(wb_valid), 32'd0);
        end
        load_data       = 32'h0000_00A5;
        load_data_valid = 1'b1;
        #1 chk("ld3_stall_release", 32'(mem_stall), 32'd0);
        chk("ld3_stall_cycles", 32'(stall_cycles), 32'd3);
        cyc();
        drive_idle();
        chk("ld3_valid", 32'(wb_valid), 32'd1);
        chk("ld3_rw",    32'(wb_reg_write), 32'd1);
        chk("ld3_rd",    32'(wb_rd), 32'd9);
        chk("ld3_data",  wb_write_data, 32'h0000_00A5);
        cyc();
        chk("ld3_retire", retire_count, 32'd3);

        // data arriving exactly on the timeout cycle wins
        drive_op(1'b1, 5'd12, 32'h0000_0300);
        for (int i = 0; i < 4; i++) begin
            #1 chk("ldt_stall", 32'(mem_stall), 32'd1);
            cyc();
        end
        load_data       = 32'h5555_AAAA;
        load_data_valid = 1'b1;
        #1 chk("ldt_stall_edge", 32'(mem_stall), 32'd0);
        cyc();
        drive_idle();
        chk("ldt_valid",   32'(wb_valid), 32'd1);
        chk("ldt_rw",      32'(wb_reg_write), 32'd1);
        chk("ldt_rd",      32'(wb_rd), 32'd12);
        chk("ldt_data",    wb_write_data, 32'h5555_AAAA);
        chk("ldt_timeout", 32'(timeout_err), 32'd0);
        cyc();
        chk("ldt_retire", retire_count, 32'd4);

        // genuine timeout: 4 stall cycles, fifth cycle releases
        drive_op(1'b1, 5'd10, 32'h0000_0400);
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_stall", 32'(mem_stall), 32'd1);
            cyc();
        end
        #1 chk("to_stall_release", 32'(mem_stall), 32'd0);
        cyc();
        drive_idle();
        chk("to_valid",   32'(wb_valid), 32'd1);
        chk("to_rw",      32'(wb_reg_write), 32'd0);
        chk("to_timeout", 32'(timeout_err), 32'd1);
        chk("to_buserr",  32'(bus_err), 32'd0);

        // next instruction proceeds after the timeout
        drive_op(1'b0, 5'd11, 32'h0000_BEEF);
        #1 chk("post_to_stall", 32'(mem_stall), 32'd0);
        cyc();
        drive_idle();
        chk("post_to_valid", 32'(wb_valid), 32'd1);
        chk("post_to_rd",    32'(wb_rd), 32'd11);
        chk("post_to_data",  wb_write_data, 32'h0000_BEEF);
        chk("post_to_timeout_sticky", 32'(timeout_err), 32'd1);

        // rd=0 never writes
        drive_op(1'b0, 5'd0, 32'hDEAD_0000);
        cyc();
        drive_idle();
        chk("x0_valid", 32'(wb_valid), 32'd1);
        chk("x0_rw",    32'(wb_reg_write), 32'd0);

        // load error response: data still written, bus_err sticky
        drive_op(1'b1, 5'd13, 32'h0000_0500);
        load_data       = 32'h1357_9BDF;
        load_data_valid = 1'b1;
        load_resp_err   = 1'b1;
        cyc();
        drive_idle();
        chk("err_valid",  32'(wb_valid), 32'd1);
        chk("err_data",   wb_write_data, 32'h1357_9BDF);
        chk("err_buserr", 32'(bus_err), 32'd1);
        cyc();
        cyc();
        chk("err_buserr_sticky", 32'(bus_err), 32'd1);
        chk("retire_mid", retire_count, 32'd8);

        // stray load_data_valid outside a load is ignored
        load_data       = 32'hCAFE_F00D;
        load_data_valid = 1'b1;
        cyc();
        drive_idle();
        chk("stray_valid", 32'(wb_valid), 32'd0);
        chk("stray_data",  wb_write_data, 32'h1357_9BDF);

        // reset while waiting on a load
        drive_op(1'b1, 5'd14, 32'h0000_0600);
        cyc();
        drive_idle();
        #1 chk("rstw_stall_pre", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_all_zero("rstw");
        load_data       = 32'h0BAD_0BAD;
        load_data_valid = 1'b1;
        cyc();
        drive_idle();
        chk("rstw_no_write", 32'(wb_valid), 32'd0);

        // retire_count wrap
        force dut.retire_count = 32'hFFFF_FFFF;
        drive_op(1'b0, 5'd1, 32'h0000_0001);
        cyc();
        release dut.retire_count;
        drive_idle();
        chk("wrap_valid", 32'(wb_valid), 32'd1);
        chk("wrap_pre",   retire_count, 32'hFFFF_FFFF);
        cyc();
        chk("wrap_post",  retire_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
